icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 122 ++++++++++++
 tb/tb_icache.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with one-word lines and one outstanding miss.
// Latency: hit 1 cycle; a miss issues its memory request 1 cycle after the fetch, and the word returns 1 cycle after in_mem_ok.
module icache #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_rollback,
    input  logic        in_if_ena,
    input  logic [31:0] in_if_addr,
    output logic        out_if_ok,
    output logic [31:0] out_if_inst,
    output logic        out_mem_ena,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ok,
    input  logic [31:0] in_mem_data
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic {IDLE, MISS_WAIT} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic                  out_if_ok_q, out_if_ok_d;
    logic [31:0]           out_if_inst_q, out_if_inst_d;
    logic                  out_mem_ena_q, out_mem_ena_d;
    logic [31:0]           out_mem_addr_q, out_mem_addr_d;

    logic                  fill_en;
    logic                  hit;
    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;

    // The outstanding miss address is the one last sent to memory.
    assign req_idx  = in_if_addr[INDEX_BITS+1:2];
    assign req_tag  = in_if_addr[INDEX_BITS+2 +: TAG_BITS];
    assign fill_idx = out_mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag = out_mem_addr_q[INDEX_BITS+2 +: TAG_BITS];
    assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        out_if_ok_d    = out_if_ok_q;
        out_if_inst_d  = out_if_inst_q;
        out_mem_ena_d  = out_mem_ena_q;
        out_mem_addr_d = out_mem_addr_q;
        fill_en        = 1'b0;
        if (in_rollback) begin
            // A fill racing the flush is still kept, but nobody is waiting for it.
            state_d       = IDLE;
            out_if_ok_d   = 1'b0;
            out_mem_ena_d = 1'b0;
            fill_en       = ena && (state_q == MISS_WAIT) && in_mem_ok;
        end else if (ena) begin
            out_if_ok_d   = 1'b0;
            out_mem_ena_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_if_ena) begin
                        if (hit) begin
                            out_if_ok_d   = 1'b1;
                            out_if_inst_d = data_mem[req_idx];
                        end else begin
                            out_mem_ena_d  = 1'b1;
                            out_mem_addr_d = in_if_addr;
                            state_d        = MISS_WAIT;
                        end
                    end
                end
                MISS_WAIT: begin
                    if (in_mem_ok) begin
                        fill_en       = 1'b1;
                        out_if_ok_d   = 1'b1;
                        out_if_inst_d = in_mem_data;
                        state_d       = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            out_if_ok_q    <= 1'b0;
            out_if_inst_q  <= '0;
            out_mem_ena_q  <= 1'b0;
            out_mem_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            out_if_ok_q    <= out_if_ok_d;
            out_if_inst_q  <= out_if_inst_d;
            out_mem_ena_q  <= out_mem_ena_d;
            out_mem_addr_q <= out_mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= in_mem_data;
        end
    end

    assign out_if_ok    = out_if_ok_q;
    assign out_if_inst  = out_if_inst_q;
    assign out_mem_ena  = out_mem_ena_q;
    assign out_mem_addr = out_mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Randomised bench for icache: a line-level cache model predicts each response, a monitor checks DUT outputs against it.
module tb_icache;
    localparam int IB    = 6;
    localparam int TB    = 10;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst, ena, in_rollback, in_if_ena, in_mem_ok;
    logic [31:0] in_if_addr, in_mem_data;
    logic        out_if_ok, out_mem_ena;
    logic [31:0] out_if_inst, out_mem_addr;

    always #5 clk = ~clk;

    icache #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_rollback(in_rollback),
        .in_if_ena(in_if_ena), .in_if_addr(in_if_addr),
        .out_if_ok(out_if_ok), .out_if_inst(out_if_inst),
        .out_mem_ena(out_mem_ena), .out_mem_addr(out_mem_addr),
        .in_mem_ok(in_mem_ok), .in_mem_data(in_mem_data)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_mem_q[$];
    logic [31:0] exp_inst_q[$];

    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    logic [31:0] m_data  [LINES];

    function automatic int idx_of(logic [31:0] a);
        return int'((a / 4) % LINES);
    endfunction

    function automatic int unsigned tag_of(logic [31:0] a);
        return (a >> (IB + 2)) % (1 << TB);
    endfunction

    function automatic bit model_hit(logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
        m_valid[idx_of(a)] = 1'b1;
        m_tag[idx_of(a)]   = tag_of(a);
        m_data[idx_of(a)]  = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every output pulse must match the oldest predicted one.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_mem_ena) begin
                    if (exp_mem_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_mem_ena: got addr %h, expected no request", out_mem_addr);
                    end else check("mem_addr", out_mem_addr, exp_mem_q.pop_front());
                end
                if (out_if_ok) begin
                    if (exp_inst_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_if_ok: got inst %h, expected no response", out_if_inst);
                    end else check("if_inst", out_if_inst, exp_inst_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_miss(input logic [31:0] a);
        exp_mem_q.push_back(a);
        in_if_ena  = 1'b1;
        in_if_addr = a;
        tick();
        in_if_ena  = 1'b0;
        check("miss_issue_latency", {31'd0, out_mem_ena}, 32'd1);
    endtask

    task automatic complete_miss(input logic [31:0] a, input logic [31:0] d);
        exp_inst_q.push_back(d);
        in_mem_ok   = 1'b1;
        in_mem_data = d;
        tick();
        in_mem_ok   = 1'b0;
        model_fill(a, d);
        check("fill_latency", {31'd0, out_if_ok}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] a, input int lat, input logic [31:0] d);
        if (model_hit(a)) begin
            exp_inst_q.push_back(m_data[idx_of(a)]);
            in_if_ena  = 1'b1;
            in_if_addr = a;
            tick();
            in_if_ena  = 1'b0;
            check("hit_latency", {31'd0, out_if_ok}, 32'd1);
        end else begin
            issue_miss(a);
            repeat (lat) tick();
            complete_miss(a, d);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; in_rollback = 1'b0; in_if_ena = 1'b0;
        in_mem_ok = 1'b0; in_if_addr = '0; in_mem_data = '0;
        model_clear();
        repeat (3) tick();
        check("rst_if_ok", {31'd0, out_if_ok}, 32'd0);
        check("rst_mem_ena", {31'd0, out_mem_ena}, 32'd0);
        check("rst_mem_addr", out_mem_addr, 32'd0);
        check("rst_if_inst", out_if_inst, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss, hit, then conflict eviction on the same index.
        fetch(32'h0000_0004, 3, 32'h0000_0013);
        fetch(32'h0000_0004, 0, 32'h0);
        fetch(32'h0000_0104, 2, 32'hA5A5_0104);
        fetch(32'h0000_0004, 1, 32'h0000_0013);

        // Flush mid-miss with no memory answer; next miss must issue at once.
        issue_miss(32'h0000_0020);
        tick();
        in_rollback = 1'b1;
        tick();
        in_rollback = 1'b0;
        check("rollback_if_ok", {31'd0, out_if_ok}, 32'd0);
        repeat (3) tick();
        fetch(32'h0000_0008, 2, 32'h1111_0008);

        // Fill racing a flush: line written, no response.
        issue_miss(32'h0000_000C);
        tick();
        in_mem_ok = 1'b1; in_mem_data = 32'hDEAD_BEEF; in_rollback = 1'b1;
        tick();
        in_mem_ok = 1'b0; in_rollback = 1'b0;
        model_fill(32'h0000_000C, 32'hDEAD_BEEF);
        check("rollback_fill_no_ok", {31'd0, out_if_ok}, 32'd0);
        tick();
        fetch(32'h0000_000C, 0, 32'h0);

        // Enable low while waiting: memory pulses are ignored until re-enabled.
        issue_miss(32'h0000_0030);
        tick();
        ena = 1'b0; in_mem_ok = 1'b1; in_mem_data = 32'hBAD0_BAD0;
        repeat (5) begin
            tick();
            check("frozen_if_ok", {31'd0, out_if_ok}, 32'd0);
        end
        in_mem_ok = 1'b0; ena = 1'b1;
        tick();
        complete_miss(32'h0000_0030, 32'h3030_3030);
        tick();

        // Stray memory ack in IDLE must not overwrite the last-missed line.
        in_mem_ok = 1'b1; in_mem_data = 32'hFFFF_0000;
        tick();
        in_mem_ok = 1'b0;
        check("stray_ok_ignored", {31'd0, out_if_ok}, 32'd0);
        fetch(32'h0000_0030, 0, 32'h0);

        // Fetch coinciding with a flush is dropped.
        in_if_ena = 1'b1; in_if_addr = 32'h0000_0040; in_rollback = 1'b1;
        tick();
        in_if_ena = 1'b0; in_rollback = 1'b0;
        check("rollback_drops_fetch", {31'd0, out_mem_ena}, 32'd0);
        fetch(32'h0000_0040, 1, 32'h4040_4040);

        // Reset abandons a pending miss and invalidates everything.
        issue_miss(32'h0000_0050);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        in_mem_ok = 1'b1; in_mem_data = 32'h5050_5050;
        tick();
        in_mem_ok = 1'b0;
        check("post_rst_ok_ignored", {31'd0, out_if_ok}, 32'd0);
        fetch(32'h0000_0004, 2, 32'h0000_0077);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 15)) << 18);
            fetch(a, int'($urandom_range(0, 4)), $urandom);
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (4) tick();
        check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
        check("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
